// File: rtl/inst_mem_loader.sv
// Streams a big-endian program image (word count, then words) into instruction memory,
// holding the CPU until the load completes. Define INST_LOADER_CHECKSUM_EN to require a
// trailing 32-bit sum of all written words before the image is accepted.
module inst_mem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        im_wr_en,
    output logic [31:0] im_wr_addr,
    output logic [31:0] im_wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StWrite,
        StDone,
`ifdef INST_LOADER_CHECKSUM_EN
        StErr,
        StCsum
`else
        StErr
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [ADDR_W:0] n_q, n_d;
    logic [ADDR_W:0] idx_q, idx_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [31:0]   sum_q, sum_d;
`endif

    logic          accept;
    logic          last_byte;
    logic [31:0]   full_word;
    logic [ADDR_W:0] idx_inc;
    logic          too_big;

    assign accept    = byte_valid && byte_ready;
    assign last_byte = accept && (cnt_q == 2'd3);
    assign full_word = {shift_q, byte_data};
    assign idx_inc   = idx_q + {{ADDR_W{1'b0}}, 1'b1};
    // N == 2^ADDR_W exactly fills the memory and is legal.
    assign too_big   = ({32'd0, full_word} > (64'd1 << ADDR_W));

    assign im_wr_addr = addr_q;
    assign im_wr_data = data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
            n_q     <= '0;
            idx_q   <= '0;
            addr_q  <= BASE_ADDR;
            data_q  <= 32'd0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        n_d     = n_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        byte_ready = 1'b0;
        im_wr_en   = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;

        // Partial bytes survive any stall because the shifter only moves on acceptance.
        if (accept) begin
            shift_d = {shift_q[15:0], byte_data};
            cnt_d   = cnt_q + 2'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StHdr;
                    cnt_d   = 2'd0;
                    idx_d   = '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_d   = 32'd0;
`endif
                end
            end

            StHdr: begin
                byte_ready = 1'b1;
                if (last_byte) begin
                    idx_d = '0;
                    if (too_big) begin
                        state_d = StErr;
                    end else if (full_word == 32'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                        state_d = StCsum;
`else
                        state_d = StDone;
`endif
                    end else begin
                        n_d     = full_word[ADDR_W:0];
                        state_d = StData;
                    end
                end
            end

            StData: begin
                byte_ready = 1'b1;
                if (last_byte) begin
                    data_d  = full_word;
                    addr_d  = BASE_ADDR + (32'(idx_q) << 2);
                    state_d = StWrite;
                end
            end

            StWrite: begin
                im_wr_en = 1'b1;
                idx_d    = idx_inc;
`ifdef INST_LOADER_CHECKSUM_EN
                sum_d    = sum_q + data_q;
`endif
                if (idx_inc == n_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    state_d = StCsum;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StData;
                end
            end

`ifdef INST_LOADER_CHECKSUM_EN
            StCsum: begin
                byte_ready = 1'b1;
                if (last_byte) begin
                    state_d = (full_word == sum_q) ? StDone : StErr;
                end
            end
`endif

            StDone: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    state_d = StHdr;
                    cnt_d   = 2'd0;
                    idx_d   = '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_d   = 32'd0;
`endif
                end
            end

            StErr: begin
                error = 1'b1;
                if (start) begin
                    state_d = StHdr;
                    cnt_d   = 2'd0;
                    idx_d   = '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_d   = 32'd0;
`endif
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: two instances (base 0 and base 0x00400000) see the
// same byte stream; monitors pop expected writes whenever im_wr_en is seen.
module tb_inst_mem_loader;

    localparam logic [31:0] Base1 = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;

    logic        br0, we0, hold0, done0, err0;
    logic [31:0] wa0, wd0;
    logic        br1, we1, hold1, done1, err1;
    logic [31:0] wa1, wd1;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] exp0[$];
    logic [63:0] exp1[$];
    logic [31:0] prog[$];
    logic [63:0] e0, e1;

    always #5 clk = ~clk;

    inst_mem_loader #(.ADDR_W(10), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(br0), .im_wr_en(we0), .im_wr_addr(wa0),
        .im_wr_data(wd0), .cpu_hold(hold0), .done(done0), .error(err0)
    );

    inst_mem_loader #(.ADDR_W(10), .BASE_ADDR(Base1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(br1), .im_wr_en(we1), .im_wr_addr(wa1),
        .im_wr_data(wd1), .cpu_hold(hold1), .done(done1), .error(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (we0 === 1'b1) begin
            if (exp0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut0 unexpected write: got %h/%h, required none", wa0, wd0);
            end else begin
                e0 = exp0.pop_front();
                check("dut0 write addr", wa0, e0[63:32]);
                check("dut0 write data", wd0, e0[31:0]);
            end
            check1("dut0 byte_ready in write", br0, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (we1 === 1'b1) begin
            if (exp1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1 unexpected write: got %h/%h, required none", wa1, wd1);
            end else begin
                e1 = exp1.pop_front();
                check("dut1 write addr", wa1, e1[63:32]);
                check("dut1 write data", wd1, e1[31:0]);
            end
            check1("dut1 byte_ready in write", br1, 1'b0);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) begin
            byte_data = 8'($urandom);
            sync();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (br0) break;
            t++;
            if (t > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL byte_ready timeout: got 0, required 1");
                byte_valid = 1'b0;
                sync();
                return;
            end
        end
        sync();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gaps);
        for (int k = 0; k < 4; k++) begin
            if (gaps > 0) idle($urandom_range(0, gaps));
            send_byte(w[31-8*k -: 8]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        sync();
        start = 1'b0;
    endtask

    // Header, words and (when enabled) checksum; expected writes are queued first.
    task automatic run_prog(input int gaps);
        logic [31:0] sum;
        sum = 32'd0;
        for (int i = 0; i < prog.size(); i++) begin
            exp0.push_back({32'(4 * i), prog[i]});
            exp1.push_back({Base1 + 32'(4 * i), prog[i]});
            sum = sum + prog[i];
        end
        send_word(32'(prog.size()), gaps);
        for (int i = 0; i < prog.size(); i++) send_word(prog[i], gaps);
`ifdef INST_LOADER_CHECKSUM_EN
        send_word(sum, gaps);
`endif
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!done0 && !err0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check1({name, " done0"}, done0, 1'b1);
        check1({name, " done1"}, done1, 1'b1);
        check1({name, " cpu_hold"}, hold0, 1'b0);
        check1({name, " error"}, err0, 1'b0);
        sync();
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(negedge clk);
        check1("reset byte_ready", br0, 1'b0);
        check1("reset im_wr_en", we0, 1'b0);
        check("reset addr0", wa0, 32'h0);
        check("reset addr1", wa1, Base1);
        check("reset data", wd0, 32'h0);
        check1("reset cpu_hold", hold0, 1'b1);
        check1("reset done", done0, 1'b0);
        check1("reset error", err0, 1'b0);
        sync();
        rst_n = 1'b1;
        sync();

        // Two-word program, contiguous bytes
        pulse_start();
        prog = '{32'h2408_0005, 32'h0000_0000};
        run_prog(0);
`ifndef INST_LOADER_CHECKSUM_EN
        @(negedge clk);
        check1("t1 strobe after last byte", we0, 1'b1);
        check1("t1 done during write", done0, 1'b0);
        @(negedge clk);
        check1("t1 done after write", done0, 1'b1);
        check1("t1 cpu_hold after write", hold0, 1'b0);
        sync();
`endif
        wait_done("t1");

        // Empty program
        pulse_start();
        prog = '{};
        run_prog(0);
`ifndef INST_LOADER_CHECKSUM_EN
        @(negedge clk);
        check1("t2 done after header", done0, 1'b1);
        sync();
`endif
        wait_done("t2");
`ifdef INST_LOADER_CHECKSUM_EN
        pulse_start();
        send_word(32'h0, 0);
        send_word(32'h1, 0);
        @(negedge clk);
        check1("t2 bad checksum error", err0, 1'b1);
        sync();
`endif

        // Oversized program (1025 words)
        pulse_start();
        send_word(32'h0000_0401, 0);
        repeat (3) begin
            @(negedge clk);
            check1("t3 error", err0, 1'b1);
            check1("t3 cpu_hold", hold0, 1'b1);
            check1("t3 byte_ready", br0, 1'b0);
        end
        sync();

        // Stalls mid-word, started from the error state
        pulse_start();
        @(negedge clk);
        check1("t4 error cleared", err0, 1'b0);
        sync();
        prog = '{32'h1122_3344, 32'hA5A5_5A5A, 32'h0000_FFFF};
        run_prog(3);
        wait_done("t4");

        // Reset after two data bytes, then reload
        pulse_start();
        send_word(32'h0000_0001, 0);
        send_byte(8'hAB);
        send_byte(8'hCD);
        rst_n = 1'b0;
        @(negedge clk);
        check1("t5 hold in reset", hold0, 1'b1);
        check1("t5 done in reset", done0, 1'b0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check1("t5 hold after reset", hold0, 1'b1);
        check1("t5 idle byte_ready", br0, 1'b0);
        sync();
        pulse_start();
        @(negedge clk);
        check1("t5 hold in header", hold0, 1'b1);
        sync();
        prog = '{32'hDEAD_BEEF};
        run_prog(0);
        wait_done("t5");

        // Reload from DONE
        pulse_start();
        @(negedge clk);
        check1("t6 done dropped", done0, 1'b0);
        check1("t6 done1 dropped", done1, 1'b0);
        check1("t6 cpu_hold raised", hold1, 1'b1);
        sync();
        prog = '{32'h1234_5678};
        run_prog(0);
        wait_done("t6");

        repeat (5) @(negedge clk);
        check("dut0 writes outstanding", 32'(exp0.size()), 32'd0);
        check("dut1 writes outstanding", 32'(exp1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
